demux_dispatch_ctrl: RTL and testbench

- Buffered dispatcher that sequences a configurable demux.
- Requesters push (destination index, data) commands into a small FIFO.
- The block drives the demux select and data from a registered output stage and raises a one-hot valid toward the addressed destination.
- It holds the command until that destination signals ready. A command stalled for too long is dropped.

---
 rtl/demux_dispatch_ctrl_if.sv | 32 +++
 rtl/demux_dispatch_ctrl.sv | 112 +++++++++++
 tb/tb_demux_dispatch_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux_dispatch_ctrl_if.sv
// Command and demux-side signals of the dispatcher. The master modport is the
// environment (requesters plus destinations); the slave modport is the dispatcher.
interface demux_dispatch_ctrl_if #(
    parameter int SEL_WIDTH  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
);
    localparam int NDEST = 2 ** SEL_WIDTH;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                  flush_i;
    logic                  push_valid_i;
    logic                  push_ready_o;
    logic [SEL_WIDTH-1:0]  push_dest_i;
    logic [DATA_WIDTH-1:0] push_data_i;
    logic [SEL_WIDTH-1:0]  sel_o;
    logic [DATA_WIDTH-1:0] data_o;
    logic [NDEST-1:0]      valid_o;
    logic [NDEST-1:0]      ready_i;
    logic [CNT_W-1:0]      count_o;
    logic                  drop_o;

    modport master (
        output flush_i, push_valid_i, push_dest_i, push_data_i, ready_i,
        input  push_ready_o, sel_o, data_o, valid_o, count_o, drop_o
    );

    modport slave (
        input  flush_i, push_valid_i, push_dest_i, push_data_i, ready_i,
        output push_ready_o, sel_o, data_o, valid_o, count_o, drop_o
    );
endinterface

// File: rtl/demux_dispatch_ctrl.sv
// Buffered demux dispatcher: FIFO of (dest, data) commands feeding a registered
// output stage that holds each command until its destination is ready or it times out.
module demux_dispatch_ctrl #(
    parameter int SEL_WIDTH  = 2,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    demux_dispatch_ctrl_if.slave bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int STALL_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic {S_EMPTY, S_HOLD} state_t;

    state_t                state_q, state_d;
    logic [SEL_WIDTH-1:0]  mem_dest [DEPTH];
    logic [DATA_WIDTH-1:0] mem_data [DEPTH];
    logic [PTR_W-1:0]      wr_ptr, rd_ptr;
    logic [CNT_W-1:0]      count_q;
    logic [SEL_WIDTH-1:0]  sel_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [STALL_W-1:0]    stall_q;
    logic                  drop_q;
    logic                  hold, transfer, timeout_hit, fifo_nempty, push, pop;

    assign hold        = (state_q == S_HOLD);
    assign transfer    = hold && bus.ready_i[sel_q];
    // A ready in the timeout cycle wins, so timeout only fires without a transfer.
    assign timeout_hit = (TIMEOUT != 0) && hold && !transfer &&
                         (stall_q == STALL_W'(TIMEOUT - 1));
    assign fifo_nempty = (count_q != '0);

    // No passthrough when full: ready depends on occupancy only.
    assign bus.push_ready_o = (count_q < CNT_W'(DEPTH)) && !rst_i;
    assign push = bus.push_valid_i && bus.push_ready_o && !bus.flush_i;
    assign pop  = fifo_nempty && !bus.flush_i && (!hold || transfer || timeout_hit);

    assign bus.sel_o   = sel_q;
    assign bus.data_o  = data_q;
    assign bus.count_o = count_q;
    assign bus.drop_o  = drop_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_EMPTY;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.flush_i) begin
            state_d = S_EMPTY;
        end else begin
            case (state_q)
                S_EMPTY: if (fifo_nempty) state_d = S_HOLD;
                S_HOLD:  if (transfer || timeout_hit) state_d = fifo_nempty ? S_HOLD : S_EMPTY;
                default: state_d = S_EMPTY;
            endcase
        end
    end

    always_comb begin
        bus.valid_o = '0;
        if (hold) bus.valid_o[sel_q] = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_dest[wr_ptr] <= bus.push_dest_i;
            mem_data[wr_ptr] <= bus.push_data_i;
        end
    end

    // Count is kept separately from the pointers so full and empty never alias.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (bus.flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sel_q   <= '0;
            data_q  <= '0;
            stall_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            drop_q <= timeout_hit && !bus.flush_i;
            if (!bus.flush_i && hold && !transfer && !timeout_hit)
                stall_q <= stall_q + STALL_W'(1);
            else
                stall_q <= '0;
            if (pop) begin
                sel_q  <= mem_dest[rd_ptr];
                data_q <= mem_data[rd_ptr];
            end
        end
    end
endmodule

// File: tb/tb_demux_dispatch_ctrl.sv
// Bench for demux_dispatch_ctrl: directed scenarios plus randomized traffic
// compared against a queue-based transaction model.
module tb_demux_dispatch_ctrl;
    localparam int SW = 2, DW = 32, DEPTH = 4, TIMEOUT = 16, NDEST = 4, CW = 3;

    typedef struct packed {
        logic [SW-1:0] dest;
        logic [DW-1:0] data;
    } cmd_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    demux_dispatch_ctrl_if #(.SEL_WIDTH(SW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) bus();
    demux_dispatch_ctrl #(.SEL_WIDTH(SW), .DATA_WIDTH(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT))
        dut (.clk_i(clk), .rst_i(rst), .bus(bus));

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: FIFO queue plus one held slot.
    cmd_t mq[$];
    bit   m_held;
    cmd_t m_cur;
    int   m_stall;
    bit   m_drop;

    task automatic model_reset();
        mq.delete();
        m_held = 0; m_stall = 0; m_drop = 0;
    endtask

    task automatic model_step(input bit pv, input cmd_t pc, input logic [NDEST-1:0] rdy, input bit fl);
        bit xfer, to, push_ok;
        push_ok = pv && (mq.size() < DEPTH);
        if (fl) begin
            model_reset();
            return;
        end
        xfer = m_held && rdy[m_cur.dest];
        to   = m_held && !xfer && (TIMEOUT != 0) && (m_stall == TIMEOUT - 1);
        m_drop  = to;
        m_stall = (m_held && !xfer && !to) ? m_stall + 1 : 0;
        if (!m_held || xfer || to) begin
            if (mq.size() > 0) begin
                m_cur  = mq.pop_front();
                m_held = 1;
            end else begin
                m_held = 0;
            end
        end
        if (push_ok) mq.push_back(pc);
    endtask

    function automatic logic [NDEST-1:0] m_valid();
        logic [NDEST-1:0] v;
        v = '0;
        if (m_held) v[m_cur.dest] = 1'b1;
        return v;
    endfunction

    // Drive one cycle of inputs, advance the model, step past the edge.
    task automatic cycle(input bit pv, input logic [SW-1:0] d, input logic [DW-1:0] dat,
                         input logic [NDEST-1:0] rdy, input bit fl);
        cmd_t c;
        c.dest = d; c.data = dat;
        bus.push_valid_i = pv;
        bus.push_dest_i  = d;
        bus.push_data_i  = dat;
        bus.ready_i      = rdy;
        bus.flush_i      = fl;
        model_step(pv, c, rdy, fl);
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.push_valid_i = 0; bus.push_dest_i = '0; bus.push_data_i = '0;
        bus.ready_i = '0; bus.flush_i = 0;
        model_reset();
        #12;
        n_checks++;
        if (bus.valid_o !== 4'b0 || bus.count_o !== 3'd0 || bus.sel_o !== 2'd0 ||
            bus.data_o !== 32'd0 || bus.drop_o !== 1'b0 || bus.push_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values valid=%b count=%0d sel=%0d data=%h drop=%b rdy=%b required all zero",
                     bus.valid_o, bus.count_o, bus.sel_o, bus.data_o, bus.drop_o, bus.push_ready_o);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        n_checks++;
        if (bus.push_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release push_ready=%b required 1", bus.push_ready_o);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_single();
        cycle(1, 2'd2, 32'h12345678, 4'b0100, 0);
        n_checks++;
        if (bus.valid_o !== 4'b0000 || bus.count_o !== 3'd1) begin
            n_fail++;
            $display("FAIL single_write valid=%b count=%0d required 0000/1", bus.valid_o, bus.count_o);
        end
        cycle(0, 2'd0, 32'd0, 4'b0100, 0);
        n_checks++;
        if (bus.valid_o !== 4'b0100 || bus.sel_o !== 2'd2 || bus.data_o !== 32'h12345678 ||
            bus.count_o !== 3'd0) begin
            n_fail++;
            $display("FAIL single_hold valid=%b sel=%0d data=%h count=%0d required 0100/2/12345678/0",
                     bus.valid_o, bus.sel_o, bus.data_o, bus.count_o);
        end
        cycle(0, 2'd0, 32'd0, 4'b0100, 0);
        n_checks++;
        if (bus.valid_o !== 4'b0000 || bus.count_o !== 3'd0) begin
            n_fail++;
            $display("FAIL single_empty valid=%b count=%0d required 0000/0", bus.valid_o, bus.count_o);
        end
    endtask

    task automatic test_fill_drain();
        for (int i = 0; i < 4; i++) cycle(1, SW'(i), 32'hA0 + i, 4'b0, 0);
        n_checks++;
        if (bus.count_o !== 3'd3 || bus.valid_o !== 4'b0001 || bus.data_o !== 32'hA0) begin
            n_fail++;
            $display("FAIL fill_three count=%0d valid=%b data=%h required 3/0001/a0",
                     bus.count_o, bus.valid_o, bus.data_o);
        end
        cycle(1, 2'd0, 32'hA4, 4'b0, 0);
        n_checks++;
        if (bus.count_o !== 3'd4 || bus.push_ready_o !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_full count=%0d push_ready=%b required 4/0", bus.count_o, bus.push_ready_o);
        end
        for (int i = 0; i < 5; i++) begin
            logic [NDEST-1:0] ev;
            ev = '0; ev[i % 4] = 1'b1;
            n_checks++;
            if (bus.valid_o !== ev || bus.data_o !== 32'hA0 + i) begin
                n_fail++;
                $display("FAIL drain_walk[%0d] valid=%b data=%h required %b/%h",
                         i, bus.valid_o, bus.data_o, ev, 32'hA0 + i);
            end
            cycle(0, 2'd0, 32'd0, 4'hF, 0);
        end
        n_checks++;
        if (bus.valid_o !== 4'b0 || bus.count_o !== 3'd0) begin
            n_fail++;
            $display("FAIL drain_done valid=%b count=%0d required 0000/0", bus.valid_o, bus.count_o);
        end
    endtask

    task automatic test_hol();
        cycle(1, 2'd1, 32'hB1, 4'b1000, 0);
        cycle(1, 2'd3, 32'hB3, 4'b1000, 0);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 2'd0, 32'd0, 4'b1000, 0);
            n_checks++;
            if (bus.sel_o !== 2'd1 || bus.valid_o !== 4'b0010 || bus.data_o !== 32'hB1) begin
                n_fail++;
                $display("FAIL hol_block[%0d] sel=%0d valid=%b data=%h required 1/0010/b1",
                         i, bus.sel_o, bus.valid_o, bus.data_o);
            end
        end
        cycle(0, 2'd0, 32'd0, 4'b0010, 0);
        n_checks++;
        if (bus.sel_o !== 2'd3 || bus.valid_o !== 4'b1000 || bus.data_o !== 32'hB3) begin
            n_fail++;
            $display("FAIL hol_release sel=%0d valid=%b data=%h required 3/1000/b3",
                     bus.sel_o, bus.valid_o, bus.data_o);
        end
        cycle(0, 2'd0, 32'd0, 4'b1000, 0);
        n_checks++;
        if (bus.valid_o !== 4'b0) begin
            n_fail++;
            $display("FAIL hol_empty valid=%b required 0000", bus.valid_o);
        end
    endtask

    task automatic test_timeout();
        cycle(1, 2'd0, 32'hC0, 4'b0, 0);
        cycle(1, 2'd1, 32'hC1, 4'b0, 0);
        for (int k = 1; k <= TIMEOUT - 1; k++) begin
            cycle(0, 2'd0, 32'd0, 4'b0, 0);
            n_checks++;
            if (bus.drop_o !== 1'b0 || bus.valid_o !== 4'b0001) begin
                n_fail++;
                $display("FAIL timeout_wait[%0d] drop=%b valid=%b required 0/0001", k, bus.drop_o, bus.valid_o);
            end
        end
        cycle(0, 2'd0, 32'd0, 4'b0, 0);
        n_checks++;
        if (bus.drop_o !== 1'b1 || bus.valid_o !== 4'b0010 || bus.data_o !== 32'hC1) begin
            n_fail++;
            $display("FAIL timeout_drop drop=%b valid=%b data=%h required 1/0010/c1",
                     bus.drop_o, bus.valid_o, bus.data_o);
        end
        for (int k = 1; k <= TIMEOUT - 1; k++) begin
            cycle(0, 2'd0, 32'd0, 4'b0, 0);
            n_checks++;
            if (bus.drop_o !== 1'b0 || bus.valid_o !== 4'b0010) begin
                n_fail++;
                $display("FAIL timeout_second[%0d] drop=%b valid=%b required 0/0010", k, bus.drop_o, bus.valid_o);
            end
        end
        cycle(0, 2'd0, 32'd0, 4'b0010, 0);
        n_checks++;
        if (bus.drop_o !== 1'b0 || bus.valid_o !== 4'b0) begin
            n_fail++;
            $display("FAIL timeout_ready_wins drop=%b valid=%b required 0/0000", bus.drop_o, bus.valid_o);
        end
        cycle(0, 2'd0, 32'd0, 4'b0, 0);
        n_checks++;
        if (bus.drop_o !== 1'b0) begin
            n_fail++;
            $display("FAIL timeout_no_late_drop drop=%b required 0", bus.drop_o);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) cycle(1, SW'($urandom_range(0, 3)), 32'hD000_0000 + i, 4'b0, 0);
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (bus.count_o !== 3'd2 || bus.data_o !== 32'hD000_0000 + k || bus.valid_o === 4'b0) begin
                n_fail++;
                $display("FAIL b2b[%0d] count=%0d data=%h valid=%b required 2/%h/nonzero",
                         k, bus.count_o, bus.data_o, bus.valid_o, 32'hD000_0000 + k);
            end
            cycle(1, SW'($urandom_range(0, 3)), 32'hD000_0003 + k, 4'hF, 0);
        end
        n_checks++;
        if (bus.count_o !== 3'd2 || bus.data_o !== 32'hD000_000A) begin
            n_fail++;
            $display("FAIL b2b_end count=%0d data=%h required 2/d000000a", bus.count_o, bus.data_o);
        end
        for (int i = 0; i < 3; i++) cycle(0, 2'd0, 32'd0, 4'hF, 0);
    endtask

    task automatic test_flush();
        for (int i = 0; i < 4; i++) cycle(1, SW'(i), 32'hE0 + i, 4'b0, 0);
        n_checks++;
        if (bus.count_o !== 3'd3 || bus.push_ready_o !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre count=%0d push_ready=%b required 3/1", bus.count_o, bus.push_ready_o);
        end
        cycle(1, 2'd2, 32'hE4, 4'b0, 1);
        n_checks++;
        if (bus.count_o !== 3'd0 || bus.valid_o !== 4'b0 || bus.drop_o !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_clear count=%0d valid=%b drop=%b required 0/0000/0",
                     bus.count_o, bus.valid_o, bus.drop_o);
        end
        cycle(0, 2'd0, 32'd0, 4'hF, 0);
        n_checks++;
        if (bus.count_o !== 3'd0 || bus.valid_o !== 4'b0) begin
            n_fail++;
            $display("FAIL flush_push_gone count=%0d valid=%b required 0/0000", bus.count_o, bus.valid_o);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            logic [NDEST-1:0] rdy;
            logic [CW-1:0]    ecnt;
            logic             erdy;
            if (n < 200) rdy = NDEST'($urandom_range(0, 15));
            else         rdy = ($urandom_range(0, 24) == 0) ? NDEST'($urandom_range(0, 15)) : '0;
            cycle($urandom_range(0, 3) != 0, SW'($urandom_range(0, 3)), $urandom, rdy,
                  $urandom_range(0, 79) == 0);
            ecnt = CW'(mq.size());
            erdy = (mq.size() < DEPTH);
            n_checks++;
            if (bus.count_o !== ecnt || bus.valid_o !== m_valid() || bus.drop_o !== m_drop ||
                bus.push_ready_o !== erdy ||
                (m_held && (bus.sel_o !== m_cur.dest || bus.data_o !== m_cur.data))) begin
                n_fail++;
                $display("FAIL random[%0d] count=%0d valid=%b drop=%b prdy=%b sel=%0d data=%h required %0d/%b/%b/%b/%0d/%h",
                         n, bus.count_o, bus.valid_o, bus.drop_o, bus.push_ready_o, bus.sel_o, bus.data_o,
                         ecnt, m_valid(), m_drop, erdy, m_cur.dest, m_cur.data);
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(0, 2'd0, 32'd0, 4'b0, 1);
        for (int i = 0; i < 3; i++) cycle(1, SW'(i + 1), 32'hF0 + i, 4'b0, 0);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if (bus.valid_o !== 4'b0 || bus.count_o !== 3'd0 || bus.sel_o !== 2'd0 ||
            bus.data_o !== 32'd0 || bus.push_ready_o !== 1'b0 || bus.drop_o !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset valid=%b count=%0d sel=%0d data=%h prdy=%b drop=%b required all zero",
                     bus.valid_o, bus.count_o, bus.sel_o, bus.data_o, bus.push_ready_o, bus.drop_o);
        end
        bus.push_valid_i = 0; bus.ready_i = 4'hF;
        @(posedge clk); #1;
        rst = 1'b0;
        cycle(0, 2'd0, 32'd0, 4'hF, 0);
        n_checks++;
        if (bus.valid_o !== 4'b0 || bus.count_o !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset_after valid=%b count=%0d required 0000/0", bus.valid_o, bus.count_o);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_hol();
        test_timeout();
        test_back_to_back();
        test_flush();
        test_random();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
